// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

   localparam int ADDR_W = 30;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } refill_state_e;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int line_words, input int lines);
      return ADDR_W - off_w(line_words) - idx_w(lines);
   endfunction

   // Word address of beat 0 of the line containing word_addr.
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] word_addr,
                                                    input int off);
      logic [ADDR_W-1:0] mask_s;
      mask_s = (30'd1 << off) - 30'd1;
      return word_addr & ~mask_s;
   endfunction

endpackage

// File: rtl/icache_refill.sv
// Refill sequencer: walks a missed line beat by beat over the req/ack memory port
// and tells the arrays when to write data and when to commit the tag.
module icache_refill
   import icache_pkg::*;
#(
   parameter int  LINE_WORDS = 4,
   localparam int OFF        = off_w(LINE_WORDS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush,
   input  logic              lookup_hit,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              idle,
   output logic              wr_en,
   output logic [OFF-1:0]    word_sel,
   output logic              tag_commit,
   output logic              commit_valid
);

   localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

   refill_state_e     state_r;
   logic [OFF-1:0]    beat_r;
   logic              flush_pend_r;
   logic              mem_req_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              ack_s;
   logic              last_ack_s;

   // Qualify the memory ack with the refill state and spot the final beat
   always_comb begin
      ack_s      = 1'b0;
      last_ack_s = 1'b0;
      if (state_r == ST_REFILL) begin
         ack_s      = mem_ack;
         last_ack_s = mem_ack && (beat_r == LAST_BEAT);
      end else begin
         ack_s      = 1'b0;
         last_ack_s = 1'b0;
      end
   end

   // Refill FSM with registered memory-port drive
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         beat_r       <= {OFF{1'b0}};
         flush_pend_r <= 1'b0;
         mem_req_r    <= 1'b0;
         mem_addr_r   <= 30'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               flush_pend_r <= 1'b0;
               beat_r       <= {OFF{1'b0}};
               if (!lookup_hit && !flush) begin
                  state_r    <= ST_REFILL;
                  mem_req_r  <= 1'b1;
                  mem_addr_r <= line_base(fetch_addr, OFF);
               end else begin
                  state_r    <= ST_IDLE;
                  mem_req_r  <= 1'b0;
                  mem_addr_r <= 30'd0;
               end
            end
            ST_REFILL: begin
               if (last_ack_s) begin
                  state_r      <= ST_IDLE;
                  beat_r       <= {OFF{1'b0}};
                  flush_pend_r <= 1'b0;
                  mem_req_r    <= 1'b0;
                  mem_addr_r   <= 30'd0;
               end else if (ack_s) begin
                  beat_r       <= beat_r + OFF'(1);
                  mem_addr_r   <= mem_addr_r + 30'd1;
                  flush_pend_r <= flush_pend_r | flush;
               end else begin
                  flush_pend_r <= flush_pend_r | flush;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               beat_r       <= {OFF{1'b0}};
               flush_pend_r <= 1'b0;
               mem_req_r    <= 1'b0;
               mem_addr_r   <= 30'd0;
            end
         endcase
      end
   end

   assign mem_req      = mem_req_r;
   assign mem_addr     = mem_addr_r;
   assign idle         = (state_r == ST_IDLE);
   assign word_sel     = beat_r;
   assign wr_en        = ack_s & ~rst_i;
   assign tag_commit   = last_ack_s & ~rst_i;
   // A flush seen at any point of the refill, including the last beat, keeps the line invalid.
   assign commit_valid = ~flush_pend_r & ~flush;

endmodule

// File: rtl/u_icache.sv
// Direct-mapped instruction cache: valid/tag/data arrays, combinational lookup,
// and a refill sequencer feeding the arrays from instruction memory.
module u_icache
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int LINES      = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:2] address_i,
   output logic [31:0] data_o,
   output logic        blocking_n_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:2] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i
);

   localparam int OFF  = off_w(LINE_WORDS);
   localparam int IDX  = idx_w(LINES);
   localparam int TAGW = tag_w(LINE_WORDS, LINES);

   logic [LINES-1:0] valid_r;
   logic [TAGW-1:0]  tag_r  [LINES];
   logic [31:0]      data_r [LINES*LINE_WORDS];

   logic [OFF-1:0]   offset_s;
   logic [IDX-1:0]   index_s;
   logic [TAGW-1:0]  tag_s;
   logic [IDX-1:0]   wr_index_s;
   logic [TAGW-1:0]  wr_tag_s;
   logic             lookup_hit_s;
   logic             idle_s;
   logic             wr_en_s;
   logic [OFF-1:0]   word_sel_s;
   logic             tag_commit_s;
   logic             commit_valid_s;

   assign offset_s = address_i[OFF+1:2];
   assign index_s  = address_i[OFF+IDX+1:OFF+2];
   assign tag_s    = address_i[31:OFF+IDX+2];

   // The refill address carries the line being filled, so the write side decodes it.
   assign wr_index_s = mem_addr_o[OFF+IDX+1:OFF+2];
   assign wr_tag_s   = mem_addr_o[31:OFF+IDX+2];

   assign lookup_hit_s = valid_r[index_s] && (tag_r[index_s] == tag_s);
   assign blocking_n_o = idle_s && lookup_hit_s;
   assign data_o       = data_r[{index_s, offset_s}];

   icache_refill #(
      .LINE_WORDS (LINE_WORDS)
   ) u_refill (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush        (flush_i),
      .lookup_hit   (lookup_hit_s),
      .fetch_addr   (address_i),
      .mem_ack      (mem_ack_i),
      .mem_req      (mem_req_o),
      .mem_addr     (mem_addr_o),
      .idle         (idle_s),
      .wr_en        (wr_en_s),
      .word_sel     (word_sel_s),
      .tag_commit   (tag_commit_s),
      .commit_valid (commit_valid_s)
   );

   // Valid bits: reset and flush clear all, a completed refill commits its line
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_r <= {LINES{1'b0}};
      end else if (flush_i) begin
         valid_r <= {LINES{1'b0}};
      end else if (tag_commit_s) begin
         valid_r[wr_index_s] <= commit_valid_s;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Data and tag arrays, written only by the refill sequencer
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         data_r[{wr_index_s, word_sel_s}] <= mem_data_i;
      end
      if (tag_commit_s) begin
         tag_r[wr_index_s] <= wr_tag_s;
      end
   end

endmodule

// File: tb/tb_u_icache.sv
// Self-checking bench for u_icache: directed scenarios with literal expectations,
// then randomized traffic against a line-residency model of the cache.
module tb_u_icache;

   localparam int LW    = 4;
   localparam int NLINE = 64;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:2] address_i;
   logic [31:0] data_o;
   logic        blocking_n_o;
   logic        flush_i;
   logic        mem_req_o;
   logic [31:2] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;

   u_icache #(.LINE_WORDS(LW), .LINES(NLINE)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .address_i    (address_i),
      .data_o       (data_o),
      .blocking_n_o (blocking_n_o),
      .flush_i      (flush_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ack_i    (mem_ack_i),
      .mem_data_i   (mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   logic        rst_v   = 1'b1;
   logic        flush_v = 1'b0;
   logic [29:0] addr_v  = 30'h40;
   int          ack_mode = 0;
   int          ack_ctr  = 0;
   bit          chk_en   = 1'b0;
   bit          exp_hit_g = 1'b0;

   // Model: which line number is resident at each index, plus the refill in flight.
   int unsigned m_res [int];
   bit          m_busy   = 1'b0;
   bit          m_poison = 1'b0;
   int unsigned m_line   = 0;
   int unsigned m_cnt    = 0;

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return 32'hA000_0000 + 32'(a) - 32'h0000_0040;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus just after the rising edge; memory answers the DUT's request.
   task automatic cycle();
      @(posedge clk_i);
      #1;
      rst_i     = rst_v;
      flush_i   = flush_v;
      address_i = addr_v;
      if (mem_req_o === 1'b1) begin
         case (ack_mode)
            0: mem_ack_i = 1'b1;
            1: begin
               mem_ack_i = (ack_ctr == 2);
               ack_ctr   = (ack_ctr == 2) ? 0 : ack_ctr + 1;
            end
            default: mem_ack_i = ($urandom_range(0, 1) == 1);
         endcase
      end else begin
         mem_ack_i = 1'b0;
         ack_ctr   = 0;
      end
      mem_data_i = mem_word(mem_addr_o);
   endtask

   task automatic settle(output int n);
      n = 0;
      while (blocking_n_o !== 1'b1 && n < 200) begin
         cycle();
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic penalty(input logic [29:0] a, output int pen);
      addr_v = a;
      cycle();
      @(negedge clk_i);
      settle(pen);
   endtask

   // Compare DUT outputs with the model every cycle, then advance the model across the edge.
   always @(negedge clk_i) begin
      int unsigned ln;
      int unsigned ix;
      bit          e_hit;
      logic [29:0] e_addr;
      if (chk_en) begin
         ln     = 32'(address_i) / LW;
         ix     = ln % NLINE;
         e_hit  = !m_busy && m_res.exists(ix) && (m_res[ix] == ln);
         e_addr = m_busy ? 30'(m_line * LW + m_cnt) : 30'd0;
         chk("blocking_n", 32'(blocking_n_o), 32'(e_hit));
         chk("mem_req", 32'(mem_req_o), 32'(m_busy));
         chk("mem_addr", 32'(mem_addr_o), 32'(e_addr));
         if (e_hit) chk("data", data_o, mem_word(address_i));
         exp_hit_g = e_hit;
         if (rst_i) begin
            m_res.delete();
            m_busy = 1'b0;
         end else if (m_busy) begin
            if (flush_i) begin
               m_poison = 1'b1;
               m_res.delete();
            end
            if (mem_ack_i) begin
               m_cnt++;
               if (m_cnt == LW) begin
                  m_busy = 1'b0;
                  if (!m_poison) m_res[m_line % NLINE] = m_line;
               end
            end
         end else if (flush_i) begin
            m_res.delete();
         end else if (!e_hit) begin
            m_busy   = 1'b1;
            m_line   = ln;
            m_cnt    = 0;
            m_poison = 1'b0;
         end
      end
   end

   initial begin
      int pen;
      logic [29:0] ra;
      rst_i      = 1'b1;
      flush_i    = 1'b0;
      address_i  = 30'h40;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'd0;
      cycle();
      cycle();
      chk_en = 1'b1;

      // Cold miss at word 0x40 with zero-wait memory
      rst_v = 1'b0;
      cycle();
      @(negedge clk_i);
      chk("cold_c0_blk", 32'(blocking_n_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         @(negedge clk_i);
         chk("cold_req", 32'(mem_req_o), 32'd1);
         chk("cold_addr", 32'(mem_addr_o), 32'h40 + 32'(k));
         chk("cold_blk", 32'(blocking_n_o), 32'd0);
      end
      cycle();
      @(negedge clk_i);
      chk("cold_c5_blk", 32'(blocking_n_o), 32'd1);
      chk("cold_data", data_o, 32'hA000_0000);

      // Hits across the rest of the line
      for (int k = 1; k < 4; k++) begin
         addr_v = 30'h40 + 30'(k);
         cycle();
         @(negedge clk_i);
         chk("line_blk", 32'(blocking_n_o), 32'd1);
         chk("line_data", data_o, 32'hA000_0000 + 32'(k));
         chk("line_req", 32'(mem_req_o), 32'd0);
      end

      // Conflict eviction at index 0x10
      penalty(30'h140, pen);
      chk("evict_pen", 32'(pen), 32'd5);
      chk("evict_data", data_o, 32'hA000_0100);
      penalty(30'h40, pen);
      chk("refetch_pen", 32'(pen), 32'd5);

      // Ack every third cycle
      ack_mode = 1;
      penalty(30'h80, pen);
      chk("wait_pen", 32'(pen), 32'd13);
      ack_mode = 0;

      // Flush pulsed at beat 2 of a refill
      addr_v = 30'hC0;
      cycle();
      cycle();
      cycle();
      flush_v = 1'b1;
      cycle();
      @(negedge clk_i);
      chk("flush_beat2", 32'(mem_addr_o), 32'hC2);
      flush_v = 1'b0;
      cycle();
      cycle();
      @(negedge clk_i);
      chk("flush_idle_blk", 32'(blocking_n_o), 32'd0);
      chk("flush_idle_req", 32'(mem_req_o), 32'd0);
      cycle();
      @(negedge clk_i);
      chk("flush_rerefill_req", 32'(mem_req_o), 32'd1);
      chk("flush_rerefill_addr", 32'(mem_addr_o), 32'hC0);
      settle(pen);
      chk("flush_settle", 32'(pen < 200), 32'd1);
      addr_v = 30'h40;
      cycle();
      @(negedge clk_i);
      chk("flush_old_miss", 32'(blocking_n_o), 32'd0);
      settle(pen);

      // Reset at beat 1
      addr_v = 30'h100;
      cycle();
      cycle();
      rst_v = 1'b1;
      cycle();
      @(negedge clk_i);
      chk("rst_beat1", 32'(mem_addr_o), 32'h101);
      rst_v = 1'b0;
      cycle();
      @(negedge clk_i);
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_blk", 32'(blocking_n_o), 32'd0);
      cycle();
      @(negedge clk_i);
      chk("rst_restart", 32'(mem_addr_o), 32'h100);
      settle(pen);
      chk("rst_settle", 32'(pen < 200), 32'd1);

      // Random traffic over a small set of conflicting lines
      ack_mode = 2;
      for (int i = 0; i < 4000; i++) begin
         if (exp_hit_g) begin
            ra = 30'(($urandom_range(0, 3) | ($urandom_range(0, 1) << 21)) << 8)
               | 30'($urandom_range(0, 7) << 2) | 30'($urandom_range(0, 3));
            addr_v = ra;
         end
         flush_v = ($urandom_range(0, 39) == 0);
         rst_v   = ($urandom_range(0, 299) == 0);
         cycle();
      end
      flush_v = 1'b0;
      rst_v   = 1'b0;
      cycle();
      @(negedge clk_i);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/u_icache.md
# u_icache

Direct-mapped instruction cache answering the fetch unit's word-address requests. Each cycle it returns the 32-bit instruction word for `address_i` combinationally and raises `blocking_n_o` on a hit. On a miss it drops `blocking_n_o` and refills the whole line from instruction memory over a single-word req/ack port. It sits between the fetch stage and the memory interconnect.

## Interface
- `LINE_WORDS`, 4: words per line; power of two, 2..16.
- `LINES`, 64: number of lines; power of two, 2..1024.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `address_i`  in  [31:2]  fetch word address.
- `data_o`  out  [31:0]  instruction word at `address_i`; valid only while `blocking_n_o`=1.
- `blocking_n_o`  out  1  1 = hit, data valid; 0 = fetch must hold.
- `flush_i`  in  1  invalidate all lines (fence.i).
- `mem_req_o`  out  1  refill beat request.
- `mem_addr_o`  out  [31:2]  refill beat word address.
- `mem_ack_i`  in  1  beat accepted; `mem_data_i` valid this cycle.
- `mem_data_i`  in  [31:0]  refill data.

## Operation
- **Address split** (OFF=log2 LINE_WORDS, IDX=log2 LINES):
  - offset = `address_i`[OFF+1:2]
  - index = next IDX bits
  - tag = remaining upper bits
  - Defaults: offset [3:2], index [9:4], tag [31:10].
- **Storage:** per line a valid bit, a tag, and LINE_WORDS data words. Reads are asynchronous.
- **hit** = (state==IDLE) & valid[index] & (tag_mem[index]==tag).
  - `blocking_n_o` = hit.
  - `data_o` = data[index][offset] (don't-care on a miss).
- **FSM states:** IDLE, REFILL.
  - IDLE, miss, no `flush_i`: latch the line base (tag, index) and go to REFILL with beat=0.
  - IDLE with `flush_i`=1: stay in IDLE.
  - REFILL: `mem_req_o`=1 and `mem_addr_o`={tag, index, beat}. Beats are always issued in order 0..LINE_WORDS-1; there is no critical-word-first.
  - On each `mem_ack_i`: write `mem_data_i` into data[index][beat], then beat+1.
  - On the ack of the last beat: write the tag, set valid unless a flush occurred during this refill, clear the flush-pending flag, and return to IDLE.
  - `mem_req_o`=0 and `mem_addr_o`=0 in IDLE.
- **Flush:**
  - Clears every valid bit in the cycle it is sampled.
  - While in REFILL it also sets flush-pending, so the line being refilled completes but stays invalid.
  - A flush on the cycle of the last ack wins: the line ends invalid.
- **Requester rule:** `address_i` is held stable while `blocking_n_o`=0. The cache does not re-check the address during REFILL.
- **Memory-side rule:** the memory tolerates `mem_req_o` deasserting without an ack (reset abort).

## Timing
- **Reset** (edge with `rst_i`=1):
  - all valid bits cleared, state IDLE, beat 0, flush-pending 0.
  - `mem_req_o`=0, `mem_addr_o`=0.
  - Data and tag arrays are not reset.
  - After reset `blocking_n_o`=0 for any address (cold cache).
- **Reset mid-refill:** aborts the refill. `mem_req_o` is 0 from the following cycle, no valid bit is set, and partially written words are discarded.
- **Hit latency:** 0 cycles, combinational from `address_i`.
- **Miss timing:**
  - Miss seen in cycle 0.
  - REFILL from cycle 1, with `mem_req_o` high from cycle 1.
  - With zero-wait memory (ack in the same cycle as req), the last ack is in cycle LINE_WORDS.
  - `blocking_n_o`=1 in cycle LINE_WORDS+1, so the default miss penalty is 5 cycles.
  - Each wait cycle on `mem_ack_i` adds one cycle.
- **Beat advance:** `mem_addr_o` advances the cycle after each ack and is stable while awaiting ack. The beat counter wraps to 0 after the last beat.
- `blocking_n_o` is combinational from `address_i` and the array state. The fetch unit samples it at the same edge as `data_o`.

## Structure
- **`icache_pkg`:**
  - state enum (IDLE, REFILL)
  - OFF/IDX/TAG width functions derived from the parameters
  - line-address helper
- **Sub-module `icache_refill`:** FSM, beat counter, flush-pending flag, and memory-port drive. It outputs the write enable, word select and tag-commit strobe.
- **`u_icache` top:** arrays, tag compare, read mux.

## Test plan
- **Cold miss:** reset, then `address_i`=0x100>>2, memory zero-wait returning 0xA000_0000+beat.
  - `mem_addr_o` sequences 0x40, 0x41, 0x42, 0x43.
  - `blocking_n_o` is 0 for cycles 0-4 and 1 in cycle 5.
  - `data_o`=0xA000_0000.
- **Line hits:** after the cold miss, step `address_i` through 0x104, 0x108, 0x10C.
  - `blocking_n_o`=1 every cycle.
  - `data_o` = 0xA000_0001, 0xA000_0002, 0xA000_0003.
  - `mem_req_o` stays 0.
- **Conflict eviction:** fill 0x100, then fetch 0x500 (same index 0x10, different tag).
  - 0x500 gives a miss and refill.
  - Refetching 0x100 misses again.
- **Wait states:** ack every third cycle on a miss.
  - Penalty is 1 + 4×3 = 13 cycles.
  - `mem_addr_o` is stable between acks.
- **Flush during refill:** pulse `flush_i` at beat 2.
  - The refill completes all 4 beats and returns to IDLE.
  - `blocking_n_o` stays 0 and a new refill of the same line starts.
  - Previously valid lines now miss.
- **Reset mid-refill:** assert `rst_i` at beat 1.
  - `mem_req_o`=0 from the next cycle.
  - After release the same address misses and refills from beat 0.
